// File: rtl/stump_misr.sv
// stump_misr: multiple-input signature register at the output end of a
// STUMPS BIST path. Each scan-chain serial output So[i] feeds MISR bit i.
// A session starts with the seed, compacts a programmed number of enabled
// shift cycles, then compares the result against a golden signature.
// The result is reported to the BIST controller on Done/Pass.
//
// Optional build macro:
//   MISR_XMASK_EN - adds the So_Mask input. A masked chain contributes 0,
//                   which blocks X values from reaching the signature.
module stump_misr #(
    parameter int MISR_Size = 64,
    parameter int CNT_W     = 32
) (
    input  logic                 clk,
    input  logic                 internalRstN,
    input  logic                 Start,
    input  logic                 Abort,
    input  logic                 MISR_En,
    input  logic [MISR_Size-1:0] MISR_Poly,
    input  logic [MISR_Size-1:0] MISR_Seed,
    input  logic [CNT_W-1:0]     Total_Cycles,
    input  logic [MISR_Size-1:0] Golden_Sig,
    input  logic [MISR_Size-1:0] So,
`ifdef MISR_XMASK_EN
    input  logic [MISR_Size-1:0] So_Mask,
`endif
    output logic [MISR_Size-1:0] MISR_Out,
    output logic                 Busy,
    output logic                 Done,
    output logic                 Pass
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COMPACT = 2'd1;
    localparam logic [1:0] ST_CHECK   = 2'd2;
    localparam logic [1:0] ST_DONE    = 2'd3;

    logic [1:0]           state;
    logic [1:0]           state_nxt;
    logic [CNT_W-1:0]     cnt;
    logic [CNT_W-1:0]     tc_q;
    logic [MISR_Size-1:0] so_eff;
    logic [MISR_Size-1:0] misr_next;
    logic                 start_ok;
    logic                 shift_en;
    logic                 last_shift;

    // Start is honoured only when no session is running.
    assign start_ok   = Start && ((state == ST_IDLE) || (state == ST_DONE));
    assign shift_en   = (state == ST_COMPACT) && MISR_En;
    // The counter stops at the terminal compare, so it can never wrap.
    assign last_shift = shift_en && (cnt == tc_q - 1'b1);

    // Chain data after optional X-masking.
    always_comb begin
`ifdef MISR_XMASK_EN
        so_eff = So & ~So_Mask;
`else
        so_eff = So;
`endif
    end

    // Galois right shift: bit 0 leaves and is fed back through the taps.
    always_comb begin
        misr_next[MISR_Size-1] = MISR_Out[0] ^ so_eff[MISR_Size-1];
        for (int i = 0; i < MISR_Size - 1; i++) begin
            misr_next[i] = (MISR_Out[0] & MISR_Poly[i]) ^ MISR_Out[i+1] ^ so_eff[i];
        end
    end

    // Session sequencing; Abort overrides everything else.
    always_comb begin
        // NOTE: default assignment first so no path leaves state_nxt unassigned (no latch).
        state_nxt = state;
        if (Abort) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (Start) begin
                        state_nxt = (Total_Cycles == '0) ? ST_CHECK : ST_COMPACT;
                    end
                end
                ST_COMPACT: begin
                    if (last_shift) begin
                        state_nxt = ST_CHECK;
                    end
                end
                ST_CHECK: state_nxt = ST_DONE;
                default:  state_nxt = ST_IDLE;
            endcase
        end
    end

    // State, registered status flags, signature, counter and compare result.
    always_ff @(posedge clk or negedge internalRstN) begin
        if (!internalRstN) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            tc_q     <= '0;
            MISR_Out <= '0;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Pass     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            state <= state_nxt;
            // Flags follow the next state, so they are registered and mutually exclusive.
            Busy  <= (state_nxt == ST_COMPACT) || (state_nxt == ST_CHECK);
            Done  <= (state_nxt == ST_DONE);
            if (Abort) begin
                cnt  <= '0;
                Pass <= 1'b0;
            end else if (start_ok) begin
                MISR_Out <= MISR_Seed;
                cnt      <= '0;
                tc_q     <= Total_Cycles;
                Pass     <= 1'b0;
            end else if (shift_en) begin
                MISR_Out <= misr_next;
                cnt      <= cnt + 1'b1;
            end else if (state == ST_CHECK) begin
                Pass <= (MISR_Out == Golden_Sig);
            end
        end
    end

endmodule

// File: tb/tb_stump_misr.sv
// Testbench for stump_misr (MISR_Size=4). Expected signatures come from a
// bench-side shift model and are queued per enabled shift, then popped and
// compared after the clock edge. Define MISR_XMASK_EN to also run the
// masking scenario.
module tb_stump_misr;

    localparam int N  = 4;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          internalRstN = 1'b0;
    logic          Start = 1'b0;
    logic          Abort = 1'b0;
    logic          MISR_En = 1'b0;
    logic [N-1:0]  MISR_Poly = '0;
    logic [N-1:0]  MISR_Seed = '0;
    logic [CW-1:0] Total_Cycles = '0;
    logic [N-1:0]  Golden_Sig = '0;
    logic [N-1:0]  So = '0;
`ifdef MISR_XMASK_EN
    logic [N-1:0]  So_Mask = '0;
`endif
    logic [N-1:0]  MISR_Out;
    logic          Busy;
    logic          Done;
    logic          Pass;

    int            n_cmp = 0;
    int            n_err = 0;
    logic [N-1:0]  exp_q[$];
    logic [N-1:0]  model = '0;

    stump_misr #(.MISR_Size(N), .CNT_W(CW)) dut (
        .clk          (clk),
        .internalRstN (internalRstN),
        .Start        (Start),
        .Abort        (Abort),
        .MISR_En      (MISR_En),
        .MISR_Poly    (MISR_Poly),
        .MISR_Seed    (MISR_Seed),
        .Total_Cycles (Total_Cycles),
        .Golden_Sig   (Golden_Sig),
        .So           (So),
`ifdef MISR_XMASK_EN
        .So_Mask      (So_Mask),
`endif
        .MISR_Out     (MISR_Out),
        .Busy         (Busy),
        .Done         (Done),
        .Pass         (Pass)
    );

    always #5 clk = ~clk;

    // Reference step written as a whole-word shift with a feedback mask.
    function automatic logic [N-1:0] ref_step(input logic [N-1:0] m,
                                              input logic [N-1:0] p,
                                              input logic [N-1:0] s);
        logic [N-1:0] fb;
        fb = m[0] ? {1'b1, p[N-2:0]} : '0;
        return (m >> 1) ^ fb ^ s;
    endfunction

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [N-1:0] seed, input logic [N-1:0] poly,
                                 input logic [CW-1:0] tc);
        MISR_Poly    = poly;
        MISR_Seed    = seed;
        Total_Cycles = tc;
        Start        = 1'b1;
        tick();
        Start        = 1'b0;
        model        = seed;
    endtask

    // Drive one enabled shift, queue its expected signature, clock it.
    task automatic drive_shift(input logic [N-1:0] so_v, input logic [N-1:0] mask_v);
        logic [N-1:0] eff;
`ifdef MISR_XMASK_EN
        So_Mask = mask_v;
        eff     = so_v & ~mask_v;
`else
        eff     = so_v | (mask_v & '0);
`endif
        MISR_En = 1'b1;
        So      = so_v;
        model   = ref_step(model, MISR_Poly, eff);
        exp_q.push_back(model);
        tick();
        MISR_En = 1'b0;
        So      = '0;
    endtask

    task automatic test_reset();
        #1;
        n_cmp++; if (MISR_Out !== '0) begin n_err++; $display("FAIL reset_misr got=%h exp=0", MISR_Out); end
        n_cmp++; if ({Busy, Done, Pass} !== 3'b000) begin n_err++; $display("FAIL reset_flags got=%b exp=000", {Busy, Done, Pass}); end
        #1 internalRstN = 1'b1;
        tick();
        n_cmp++; if ({Busy, Done, Pass} !== 3'b000) begin n_err++; $display("FAIL idle_flags got=%b exp=000", {Busy, Done, Pass}); end
    endtask

    // Seed 0, poly 0011, Tc=2, So 0001 then 0000.
    task automatic test_compact(input logic [N-1:0] golden, input logic exp_pass);
        logic [N-1:0] expd;
        start_session(4'b0000, 4'b0011, 8'd2);
        Golden_Sig = ~golden;
        n_cmp++; if ({Busy, Done, MISR_Out} !== {2'b10, 4'b0000}) begin n_err++; $display("FAIL compact_start got=%b%b/%b exp=10/0000", Busy, Done, MISR_Out); end
        drive_shift(4'b0001, 4'b0000);
        expd = exp_q.pop_front();
        n_cmp++; if (MISR_Out !== expd) begin n_err++; $display("FAIL compact_shift1 got=%b exp=%b", MISR_Out, expd); end
        drive_shift(4'b0000, 4'b0000);
        expd = exp_q.pop_front();
        n_cmp++; if (MISR_Out !== expd || expd !== 4'b1011) begin n_err++; $display("FAIL compact_shift2 got=%b model=%b exp=1011", MISR_Out, expd); end
        n_cmp++; if ({Busy, Done} !== 2'b10) begin n_err++; $display("FAIL compact_check got=%b exp=10", {Busy, Done}); end
        Golden_Sig = golden;
        tick();
        Golden_Sig = ~golden;
        n_cmp++; if ({Busy, Done, Pass} !== {2'b01, exp_pass}) begin n_err++; $display("FAIL compact_done got=%b exp=01%b", {Busy, Done, Pass}, exp_pass); end
        tick();
        n_cmp++; if ({Done, Pass, MISR_Out} !== {1'b1, exp_pass, 4'b1011}) begin n_err++; $display("FAIL compact_hold got=%b exp=1%b1011", {Done, Pass, MISR_Out}, exp_pass); end
    endtask

    task automatic test_hold();
        logic [N-1:0] expd;
        start_session(4'b0000, 4'b0011, 8'd2);
        drive_shift(4'b0001, 4'b0000);
        expd = exp_q.pop_front();
        n_cmp++; if (MISR_Out !== expd) begin n_err++; $display("FAIL hold_shift1 got=%b exp=%b", MISR_Out, expd); end
        for (int k = 0; k < 3; k++) begin
            So = 4'b1111;
            tick();
            n_cmp++; if ({Busy, Done, MISR_Out} !== {2'b10, 4'b0001}) begin n_err++; $display("FAIL hold_idle%0d got=%b exp=100001", k, {Busy, Done, MISR_Out}); end
        end
        drive_shift(4'b0000, 4'b0000);
        expd = exp_q.pop_front();
        n_cmp++; if (MISR_Out !== 4'b1011 || Done !== 1'b0) begin n_err++; $display("FAIL hold_shift2 got=%b/%b exp=1011/0", MISR_Out, Done); end
        Golden_Sig = 4'b1011;
        tick();
        n_cmp++; if ({Done, Pass} !== 2'b11) begin n_err++; $display("FAIL hold_done got=%b exp=11", {Done, Pass}); end
    endtask

    task automatic test_zero_tc();
        Golden_Sig = 4'hA;
        start_session(4'hA, 4'b0011, 8'd0);
        MISR_En = 1'b1;
        So      = 4'b0101;
        n_cmp++; if ({Busy, Done, MISR_Out} !== {2'b10, 4'hA}) begin n_err++; $display("FAIL tc0_check got=%b exp=101010", {Busy, Done, MISR_Out}); end
        tick();
        MISR_En = 1'b0;
        So      = '0;
        n_cmp++; if ({Busy, Done, Pass, MISR_Out} !== {3'b011, 4'hA}) begin n_err++; $display("FAIL tc0_done got=%b exp=0111010", {Busy, Done, Pass, MISR_Out}); end
    endtask

    task automatic test_abort();
        logic [N-1:0] expd;
        // Abort from DONE clears the result.
        Abort = 1'b1;
        tick();
        Abort = 1'b0;
        n_cmp++; if ({Busy, Done, Pass} !== 3'b000) begin n_err++; $display("FAIL abort_done got=%b exp=000", {Busy, Done, Pass}); end
        start_session(4'b0000, 4'b0011, 8'd2);
        drive_shift(4'b0001, 4'b0000);
        expd = exp_q.pop_front();
        n_cmp++; if (MISR_Out !== expd) begin n_err++; $display("FAIL abort_shift1 got=%b exp=%b", MISR_Out, expd); end
        Abort = 1'b1; Start = 1'b1; MISR_En = 1'b1; So = 4'b0110; MISR_Seed = 4'hC;
        tick();
        Abort = 1'b0; Start = 1'b0;
        n_cmp++; if ({Busy, Done, Pass, MISR_Out} !== {3'b000, 4'b0001}) begin n_err++; $display("FAIL abort_idle got=%b exp=0000001", {Busy, Done, Pass, MISR_Out}); end
        tick();
        tick();
        MISR_En = 1'b0; So = '0;
        n_cmp++; if ({Busy, MISR_Out} !== {1'b0, 4'b0001}) begin n_err++; $display("FAIL abort_no_shift got=%b exp=00001", {Busy, MISR_Out}); end
        start_session(4'h5, 4'b1001, 8'd1);
        n_cmp++; if ({Busy, MISR_Out} !== {1'b1, 4'h5}) begin n_err++; $display("FAIL abort_reseed got=%b exp=10101", {Busy, MISR_Out}); end
        drive_shift(4'b0011, 4'b0000);
        expd = exp_q.pop_front();
        n_cmp++; if (MISR_Out !== expd) begin n_err++; $display("FAIL abort_reseed_shift got=%b exp=%b", MISR_Out, expd); end
        Golden_Sig = expd;
        tick();
        n_cmp++; if ({Done, Pass} !== 2'b11) begin n_err++; $display("FAIL abort_reseed_done got=%b exp=11", {Done, Pass}); end
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] expd;
        logic [N-1:0] poly;
        logic         want_pass;
        int           tc;
        int           shifts;
        for (int sess = 0; sess < 8; sess++) begin
            tc   = int'($urandom_range(1, 6));
            poly = N'($urandom);
            start_session(N'($urandom), poly, CW'(tc));
            shifts = 0;
            for (int cyc = 0; cyc < 40 && shifts < tc; cyc++) begin
                Golden_Sig = N'($urandom);
                if ($urandom_range(0, 3) != 0) begin
                    drive_shift(N'($urandom), 4'b0000);
                    shifts++;
                    expd = exp_q.pop_front();
                    n_cmp++; if (MISR_Out !== expd) begin n_err++; $display("FAIL b2b_shift s%0d got=%b exp=%b", sess, MISR_Out, expd); end
                end else begin
                    So = N'($urandom);
                    tick();
                    n_cmp++; if (MISR_Out !== model || Busy !== 1'b1) begin n_err++; $display("FAIL b2b_gap s%0d got=%b/%b exp=%b/1", sess, MISR_Out, Busy, model); end
                end
            end
            want_pass  = 1'($urandom_range(0, 1));
            Golden_Sig = want_pass ? model : (model ^ 4'b1000);
            tick();
            n_cmp++; if ({Busy, Done, Pass} !== {2'b01, want_pass}) begin n_err++; $display("FAIL b2b_done s%0d got=%b exp=01%b", sess, {Busy, Done, Pass}, want_pass); end
        end
    endtask

`ifdef MISR_XMASK_EN
    task automatic test_xmask();
        logic [N-1:0] expd;
        start_session(4'b0000, 4'b0011, 8'd2);
        drive_shift(4'b1111, 4'b1110);
        expd = exp_q.pop_front();
        n_cmp++; if (MISR_Out !== 4'b0001 || expd !== 4'b0001) begin n_err++; $display("FAIL xmask_shift1 got=%b exp=0001", MISR_Out); end
        drive_shift(4'b0000, 4'b1110);
        expd = exp_q.pop_front();
        n_cmp++; if (MISR_Out !== 4'b1011) begin n_err++; $display("FAIL xmask_shift2 got=%b exp=1011", MISR_Out); end
        So_Mask    = '0;
        Golden_Sig = 4'b1011;
        tick();
        n_cmp++; if ({Done, Pass} !== 2'b11) begin n_err++; $display("FAIL xmask_done got=%b exp=11", {Done, Pass}); end
    endtask
`endif

    task automatic test_reset_mid();
        logic [N-1:0] expd;
        start_session(4'hF, 4'b0011, 8'd5);
        drive_shift(4'b0000, 4'b0000);
        expd = exp_q.pop_front();
        n_cmp++; if (MISR_Out !== expd || Busy !== 1'b1) begin n_err++; $display("FAIL rst_mid_pre got=%b/%b exp=%b/1", MISR_Out, Busy, expd); end
        #1 internalRstN = 1'b0;
        #1;
        n_cmp++; if ({Busy, Done, Pass, MISR_Out} !== 7'b0) begin n_err++; $display("FAIL rst_mid_async got=%b exp=0000000", {Busy, Done, Pass, MISR_Out}); end
        #1 internalRstN = 1'b1;
        MISR_En = 1'b1;
        tick();
        MISR_En = 1'b0;
        n_cmp++; if ({Busy, MISR_Out} !== 5'b0) begin n_err++; $display("FAIL rst_mid_idle got=%b exp=00000", {Busy, MISR_Out}); end
    endtask

    initial begin
        test_reset();
        test_compact(4'b1011, 1'b1);
        test_compact(4'b1010, 1'b0);
        test_hold();
        test_zero_tc();
        test_abort();
        test_back_to_back();
`ifdef MISR_XMASK_EN
        test_xmask();
`endif
        test_reset_mid();
        n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_left got=%0d exp=0", exp_q.size()); end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
